// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin write-back arbiter for the register file write port
module wb_fifo #(
    parameter int D_WIDTH = 32,
    parameter int A_WIDTH = 5,
    parameter int DEPTH   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push_valid,
    output logic               push_ready,
    input  logic [A_WIDTH-1:0] push_rd,
    input  logic [D_WIDTH-1:0] push_data,
    input  logic               pop,
    output logic               nonempty,
    output logic [A_WIDTH-1:0] head_rd,
    output logic [D_WIDTH-1:0] head_data,
    input  logic [A_WIDTH-1:0] q_addr,
    output logic               q_hit
);
    localparam int PW = $clog2(DEPTH);

    logic [A_WIDTH-1:0] rd_mem   [DEPTH];
    logic [D_WIDTH-1:0] data_mem [DEPTH];
    logic [PW:0]        wptr;
    logic [PW:0]        rptr;
    logic [PW:0]        count;
    logic               full;
    logic               push_ok;
    logic [PW-1:0]      off;

    assign count      = wptr - rptr;
    assign full       = count[PW];
    assign nonempty   = (count != '0);
    assign push_ready = !full && rst_n;
    // x0 writes complete the handshake but are dropped here
    assign push_ok    = push_valid && push_ready && (push_rd != '0);
    assign head_rd    = rd_mem[rptr[PW-1:0]];
    assign head_data  = data_mem[rptr[PW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push_ok) wptr <= wptr + 1'b1;
            if (pop)     rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            rd_mem[wptr[PW-1:0]]   <= push_rd;
            data_mem[wptr[PW-1:0]] <= push_data;
        end
    end

    // a slot is live when its distance from the read pointer is below the fill count
    always_comb begin
        q_hit = 1'b0;
        off   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = PW'(i) - rptr[PW-1:0];
            if (({1'b0, off} < count) && (rd_mem[i] == q_addr)) q_hit = 1'b1;
        end
    end
endmodule

module regfile_wb_arbiter #(
    parameter int D_WIDTH = 32,
    parameter int A_WIDTH = 5,
    parameter int DEPTH   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               alu_valid,
    output logic               alu_ready,
    input  logic [A_WIDTH-1:0] alu_rd,
    input  logic [D_WIDTH-1:0] alu_data,
    input  logic               ld_valid,
    output logic               ld_ready,
    input  logic [A_WIDTH-1:0] ld_rd,
    input  logic [D_WIDTH-1:0] ld_data,
    output logic               we,
    output logic [A_WIDTH-1:0] wa,
    output logic [D_WIDTH-1:0] wd,
    input  logic [A_WIDTH-1:0] q_addr,
    output logic               q_pending
);
    typedef enum logic {GRANT_ALU = 1'b0, GRANT_LD = 1'b1} grant_t;

    grant_t             last_grant;
    logic               alu_ne, ld_ne;
    logic               alu_hit, ld_hit;
    logic               grant_alu, grant_ld;
    logic [A_WIDTH-1:0] alu_head_rd, ld_head_rd;
    logic [D_WIDTH-1:0] alu_head_data, ld_head_data;

    wb_fifo #(.D_WIDTH(D_WIDTH), .A_WIDTH(A_WIDTH), .DEPTH(DEPTH)) u_alu_fifo (
        .clk(clk), .rst_n(rst_n),
        .push_valid(alu_valid), .push_ready(alu_ready),
        .push_rd(alu_rd), .push_data(alu_data),
        .pop(grant_alu), .nonempty(alu_ne),
        .head_rd(alu_head_rd), .head_data(alu_head_data),
        .q_addr(q_addr), .q_hit(alu_hit)
    );

    wb_fifo #(.D_WIDTH(D_WIDTH), .A_WIDTH(A_WIDTH), .DEPTH(DEPTH)) u_ld_fifo (
        .clk(clk), .rst_n(rst_n),
        .push_valid(ld_valid), .push_ready(ld_ready),
        .push_rd(ld_rd), .push_data(ld_data),
        .pop(grant_ld), .nonempty(ld_ne),
        .head_rd(ld_head_rd), .head_data(ld_head_data),
        .q_addr(q_addr), .q_hit(ld_hit)
    );

    // on a tie the source not served last time wins
    assign grant_alu = alu_ne && (!ld_ne || (last_grant == GRANT_LD));
    assign grant_ld  = ld_ne && !grant_alu;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            we         <= 1'b0;
            wa         <= '0;
            wd         <= '0;
            last_grant <= GRANT_LD;
        end else if (grant_alu) begin
            we         <= 1'b1;
            wa         <= alu_head_rd;
            wd         <= alu_head_data;
            last_grant <= GRANT_ALU;
        end else if (grant_ld) begin
            we         <= 1'b1;
            wa         <= ld_head_rd;
            wd         <= ld_head_data;
            last_grant <= GRANT_LD;
        end else begin
            we         <= 1'b0;
        end
    end

    assign q_pending = (q_addr != '0) && (alu_hit || ld_hit || (we && (wa == q_addr)));
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed vectors plus randomized model check for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid, ld_valid;
    logic        alu_ready, ld_ready;
    logic [4:0]  alu_rd, ld_rd, wa, q_addr;
    logic [31:0] alu_data, ld_data, wd;
    logic        we, q_pending;

    int checks = 0;
    int failures = 0;

    regfile_wb_arbiter #(.D_WIDTH(32), .A_WIDTH(5), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
        .we(we), .wa(wa), .wd(wd),
        .q_addr(q_addr), .q_pending(q_pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic av, input logic [4:0] ard, input logic [31:0] adat,
                         input logic lv, input logic [4:0] lrd, input logic [31:0] ldat, input logic [4:0] qa);
        rst_n = r; alu_valid = av; alu_rd = ard; alu_data = adat;
        ld_valid = lv; ld_rd = lrd; ld_data = ldat; q_addr = qa;
    endtask

    typedef struct {
        logic r, av; logic [4:0] ard; logic [31:0] adat;
        logic lv; logic [4:0] lrd; logic [31:0] ldat; logic [4:0] qa;
        logic ear, elr, eqp, ewe; logic [4:0] ewa; logic [31:0] ewd;
    } vec_t;

    function automatic vec_t mk(logic r, logic av, logic [4:0] ard, logic [31:0] adat,
                                logic lv, logic [4:0] lrd, logic [31:0] ldat, logic [4:0] qa,
                                logic ear, logic elr, logic eqp, logic ewe, logic [4:0] ewa, logic [31:0] ewd);
        vec_t v;
        v.r = r; v.av = av; v.ard = ard; v.adat = adat; v.lv = lv; v.lrd = lrd; v.ldat = ldat; v.qa = qa;
        v.ear = ear; v.elr = elr; v.eqp = eqp; v.ewe = ewe; v.ewa = ewa; v.ewd = ewd;
        return v;
    endfunction

    // Reference model: queues of pending writes plus the output registers
    typedef struct packed { logic [4:0] rd; logic [31:0] data; } wb_t;
    wb_t         mq_alu[$];
    wb_t         mq_ld[$];
    logic        m_last_ld;
    logic        m_we;
    logic [4:0]  m_wa;
    logic [31:0] m_wd;
    logic        m_from_ld;

    task automatic model_cycle(input string tag, input logic r, input logic av, input logic [4:0] ard,
                               input logic [31:0] adat, input logic lv, input logic [4:0] lrd,
                               input logic [31:0] ldat, input logic [4:0] qa,
                               output logic a_acc, output logic l_acc);
        logic ear, elr, eqp;
        wb_t  h;
        drive(r, av, ard, adat, lv, lrd, ldat, qa);
        #1;
        ear = r && (mq_alu.size() < DEPTH);
        elr = r && (mq_ld.size() < DEPTH);
        eqp = m_we && (m_wa == qa);
        foreach (mq_alu[i]) if (mq_alu[i].rd == qa) eqp = 1'b1;
        foreach (mq_ld[i])  if (mq_ld[i].rd == qa)  eqp = 1'b1;
        if (qa == 5'd0) eqp = 1'b0;
        chk({tag, "_alu_ready"}, 32'(alu_ready), 32'(ear));
        chk({tag, "_ld_ready"}, 32'(ld_ready), 32'(elr));
        chk({tag, "_q_pending"}, 32'(q_pending), 32'(eqp));
        a_acc = av && ear;
        l_acc = lv && elr;
        if (!r) begin
            mq_alu.delete(); mq_ld.delete();
            m_we = 1'b0; m_wa = '0; m_wd = '0; m_last_ld = 1'b1;
        end else begin
            if (mq_alu.size() > 0 && (mq_ld.size() == 0 || m_last_ld)) begin
                h = mq_alu.pop_front();
                m_we = 1'b1; m_wa = h.rd; m_wd = h.data; m_last_ld = 1'b0; m_from_ld = 1'b0;
            end else if (mq_ld.size() > 0) begin
                h = mq_ld.pop_front();
                m_we = 1'b1; m_wa = h.rd; m_wd = h.data; m_last_ld = 1'b1; m_from_ld = 1'b1;
            end else begin
                m_we = 1'b0;
            end
            if (a_acc && ard != 5'd0) mq_alu.push_back({ard, adat});
            if (l_acc && lrd != 5'd0) mq_ld.push_back({lrd, ldat});
        end
        @(posedge clk);
        #1;
        chk({tag, "_we"}, 32'(we), 32'(m_we));
        chk({tag, "_wa"}, 32'(wa), 32'(m_wa));
        chk({tag, "_wd"}, wd, m_wd);
        @(negedge clk);
    endtask

    vec_t vecs[$];

    initial begin
        logic        a_acc, l_acc, av, lv;
        logic [4:0]  ard, lrd, qa;
        logic [31:0] adat, ldat;
        int          we_cnt, alt_bad;
        logic        prev_ld;

        drive(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, '0);

        //        r av ard adat           lv lrd ldat          qa   ar lr qp we wa  wd
        vecs.push_back(mk(0,0, 0,32'h0,        0, 0,32'h0,        0,  0,0,0, 0, 0,32'h0));
        vecs.push_back(mk(1,0, 0,32'h0,        0, 0,32'h0,        5,  1,1,0, 0, 0,32'h0));
        vecs.push_back(mk(1,1, 5,32'hDEADBEEF, 0, 0,32'h0,        5,  1,1,0, 0, 0,32'h0));
        vecs.push_back(mk(1,0, 0,32'h0,        0, 0,32'h0,        5,  1,1,1, 1, 5,32'hDEADBEEF));
        vecs.push_back(mk(1,0, 0,32'h0,        0, 0,32'h0,        5,  1,1,1, 0, 5,32'hDEADBEEF));
        vecs.push_back(mk(1,0, 0,32'h0,        0, 0,32'h0,        5,  1,1,0, 0, 5,32'hDEADBEEF));
        vecs.push_back(mk(0,0, 0,32'h0,        0, 0,32'h0,        0,  0,0,0, 0, 0,32'h0));
        vecs.push_back(mk(1,1, 1,32'h11,       1, 2,32'h22,       2,  1,1,0, 0, 0,32'h0));
        vecs.push_back(mk(1,1, 3,32'h33,       1, 4,32'h44,       2,  1,1,1, 1, 1,32'h11));
        vecs.push_back(mk(1,0, 0,32'h0,        0, 0,32'h0,        4,  1,0,1, 1, 2,32'h22));
        vecs.push_back(mk(1,0, 0,32'h0,        0, 0,32'h0,        4,  1,1,1, 1, 3,32'h33));
        vecs.push_back(mk(1,0, 0,32'h0,        0, 0,32'h0,        4,  1,1,1, 1, 4,32'h44));
        vecs.push_back(mk(1,0, 0,32'h0,        0, 0,32'h0,        4,  1,1,1, 0, 4,32'h44));
        vecs.push_back(mk(1,1, 0,32'hFFFFFFFF, 0, 0,32'h0,        0,  1,1,0, 0, 4,32'h44));
        vecs.push_back(mk(1,0, 0,32'h0,        0, 0,32'h0,        0,  1,1,0, 0, 4,32'h44));
        vecs.push_back(mk(1,0, 0,32'h0,        0, 0,32'h0,        0,  1,1,0, 0, 4,32'h44));
        vecs.push_back(mk(1,1, 6,32'h66,       1, 7,32'h70,       7,  1,1,0, 0, 4,32'h44));
        vecs.push_back(mk(1,1, 8,32'h88,       1, 7,32'h71,       7,  1,1,1, 1, 6,32'h66));
        vecs.push_back(mk(1,0, 0,32'h0,        1, 7,32'h72,       7,  1,0,1, 1, 7,32'h70));
        vecs.push_back(mk(1,0, 0,32'h0,        1, 7,32'h72,       7,  1,1,1, 1, 8,32'h88));
        vecs.push_back(mk(1,0, 0,32'h0,        0, 0,32'h0,        7,  1,0,1, 1, 7,32'h71));
        vecs.push_back(mk(1,0, 0,32'h0,        0, 0,32'h0,        7,  1,1,1, 1, 7,32'h72));
        vecs.push_back(mk(1,0, 0,32'h0,        0, 0,32'h0,        7,  1,1,1, 0, 7,32'h72));
        vecs.push_back(mk(1,1,10,32'hA0,       1,11,32'hB0,      10,  1,1,0, 0, 7,32'h72));
        vecs.push_back(mk(1,1,12,32'hA1,       1,13,32'hB1,      10,  1,1,1, 1,10,32'hA0));
        vecs.push_back(mk(0,1,14,32'hA2,       0, 0,32'h0,       11,  0,0,1, 0, 0,32'h0));
        vecs.push_back(mk(1,0, 0,32'h0,        0, 0,32'h0,       11,  1,1,0, 0, 0,32'h0));
        vecs.push_back(mk(1,0, 0,32'h0,        0, 0,32'h0,       13,  1,1,0, 0, 0,32'h0));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].r, vecs[i].av, vecs[i].ard, vecs[i].adat,
                  vecs[i].lv, vecs[i].lrd, vecs[i].ldat, vecs[i].qa);
            #1;
            chk($sformatf("vec%0d_alu_ready", i), 32'(alu_ready), 32'(vecs[i].ear));
            chk($sformatf("vec%0d_ld_ready", i), 32'(ld_ready), 32'(vecs[i].elr));
            chk($sformatf("vec%0d_q_pending", i), 32'(q_pending), 32'(vecs[i].eqp));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_we", i), 32'(we), 32'(vecs[i].ewe));
            chk($sformatf("vec%0d_wa", i), 32'(wa), 32'(vecs[i].ewa));
            chk($sformatf("vec%0d_wd", i), wd, vecs[i].ewd);
            @(negedge clk);
        end

        // randomized traffic with held payloads and occasional reset
        m_last_ld = 1'b1; m_we = 1'b0; m_wa = '0; m_wd = '0; m_from_ld = 1'b0;
        model_cycle("rnd_rst", 1'b0, 1'b0, '0, '0, 1'b0, '0, '0, '0, a_acc, l_acc);
        av = 1'b0; lv = 1'b0; ard = '0; lrd = '0; adat = '0; ldat = '0;
        for (int c = 0; c < 400; c++) begin
            logic r;
            r = ($urandom_range(0, 59) != 0);
            if (!av) begin
                av = $urandom_range(0, 2) != 0; ard = 5'($urandom_range(0, 7)); adat = $urandom;
            end
            if (!lv) begin
                lv = $urandom_range(0, 2) != 0; lrd = 5'($urandom_range(0, 7)); ldat = $urandom;
            end
            qa = 5'($urandom_range(0, 7));
            model_cycle($sformatf("rnd%0d", c), r, av, ard, adat, lv, lrd, ldat, qa, a_acc, l_acc);
            if (a_acc || !r) av = 1'b0;
            if (l_acc || !r) lv = 1'b0;
        end

        // saturated streams from both sources
        model_cycle("str_rst", 1'b0, 1'b0, '0, '0, 1'b0, '0, '0, '0, a_acc, l_acc);
        ard = 5'($urandom_range(1, 31)); adat = $urandom;
        lrd = 5'($urandom_range(1, 31)); ldat = $urandom;
        we_cnt = 0; alt_bad = 0; prev_ld = 1'b1;
        for (int c = 0; c < 100; c++) begin
            qa = ard;
            model_cycle($sformatf("str%0d", c), 1'b1, 1'b1, ard, adat, 1'b1, lrd, ldat, qa, a_acc, l_acc);
            if (we) begin
                we_cnt++;
                if (m_from_ld == prev_ld) alt_bad++;
                prev_ld = m_from_ld;
            end
            if (a_acc) begin ard = 5'($urandom_range(1, 31)); adat = $urandom; end
            if (l_acc) begin lrd = 5'($urandom_range(1, 31)); ldat = $urandom; end
        end
        chk("stream_write_count", 32'(we_cnt), 32'd99);
        chk("stream_alternation", 32'(alt_bad), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
